// File: rtl/uart_reg_bridge.sv
// UART command engine: pops W/R frames from the RX FIFO, drives a byte-wide register bus,
// and pushes one response byte per frame. Optional trailing XOR checksum: `define UART_BRIDGE_CHKSUM_EN.
`timescale 1ns/1ps

module uart_reg_bridge #(
    parameter int              DBIT        = 8,
    parameter logic [DBIT-1:0] CMD_WR      = 8'h57,
    parameter logic [DBIT-1:0] CMD_RD      = 8'h52,
    parameter logic [DBIT-1:0] RSP_ACK     = 8'h4B,
    parameter logic [DBIT-1:0] RSP_ERR     = 8'h45,
    parameter int              TIMEOUT_CYC = 100000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    input  logic            tx_full,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic            reg_wr,
    output logic            reg_rd,
    output logic [DBIT-1:0] reg_addr,
    output logic [DBIT-1:0] reg_wdata,
    input  logic [DBIT-1:0] reg_rdata,
    output logic            busy,
    output logic            frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        CMD_REQ, CMD_CAP, ADDR_REQ, ADDR_CAP, DATA_REQ, DATA_CAP,
`ifdef UART_BRIDGE_CHKSUM_EN
        CHK_REQ, CHK_CAP,
`endif
        WR_ISSUE, RD_ISSUE, RD_CAP, SEND
    } state_t;

    state_t          state, state_n;
    logic [DBIT-1:0] cmd;
    logic [DBIT-1:0] resp, resp_n;
    logic [TW-1:0]   tmo_cnt, tmo_n;
`ifdef UART_BRIDGE_CHKSUM_EN
    logic [DBIT-1:0] chk_exp;
    assign chk_exp = cmd ^ reg_addr ^ ((cmd == CMD_WR) ? reg_wdata : '0);
`endif

    assign busy   = (state != CMD_REQ);
    assign w_data = resp;

    // NOTE: every combinational output gets a default before the case so no path infers a latch.
    always_comb begin
        state_n   = state;
        resp_n    = resp;
        tmo_n     = tmo_cnt;
        rd_uart   = 1'b0;
        wr_uart   = 1'b0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        frame_err = 1'b0;
        unique case (state)
            CMD_REQ: begin
                rd_uart = !rx_empty;
                if (!rx_empty) state_n = CMD_CAP;
            end
            CMD_CAP: begin
                tmo_n = '0;
                if (r_data == CMD_WR || r_data == CMD_RD) begin
                    state_n = ADDR_REQ;
                end else begin
                    resp_n    = RSP_ERR;
                    frame_err = 1'b1;
                    state_n   = SEND;
                end
            end
            ADDR_REQ: begin
                rd_uart = !rx_empty;
                if (!rx_empty)                 state_n = ADDR_CAP;
                else if (tmo_cnt == TMO_LAST) begin
                    frame_err = 1'b1;
                    tmo_n     = '0;
                    state_n   = CMD_REQ;
                end else                       tmo_n = tmo_cnt + TW'(1);
            end
            ADDR_CAP: begin
                tmo_n = '0;
`ifdef UART_BRIDGE_CHKSUM_EN
                state_n = (cmd == CMD_WR) ? DATA_REQ : CHK_REQ;
`else
                state_n = (cmd == CMD_WR) ? DATA_REQ : RD_ISSUE;
`endif
            end
            DATA_REQ: begin
                rd_uart = !rx_empty;
                if (!rx_empty)                 state_n = DATA_CAP;
                else if (tmo_cnt == TMO_LAST) begin
                    frame_err = 1'b1;
                    tmo_n     = '0;
                    state_n   = CMD_REQ;
                end else                       tmo_n = tmo_cnt + TW'(1);
            end
            DATA_CAP: begin
                tmo_n = '0;
`ifdef UART_BRIDGE_CHKSUM_EN
                state_n = CHK_REQ;
`else
                state_n = WR_ISSUE;
`endif
            end
`ifdef UART_BRIDGE_CHKSUM_EN
            CHK_REQ: begin
                rd_uart = !rx_empty;
                if (!rx_empty)                 state_n = CHK_CAP;
                else if (tmo_cnt == TMO_LAST) begin
                    frame_err = 1'b1;
                    tmo_n     = '0;
                    state_n   = CMD_REQ;
                end else                       tmo_n = tmo_cnt + TW'(1);
            end
            CHK_CAP: begin
                tmo_n = '0;
                if (r_data == chk_exp) begin
                    state_n = (cmd == CMD_WR) ? WR_ISSUE : RD_ISSUE;
                end else begin
                    resp_n    = RSP_ERR;
                    frame_err = 1'b1;
                    state_n   = SEND;
                end
            end
`endif
            WR_ISSUE: begin
                reg_wr  = 1'b1;
                resp_n  = RSP_ACK;
                state_n = SEND;
            end
            RD_ISSUE: begin
                reg_rd  = 1'b1;
                state_n = RD_CAP;
            end
            RD_CAP: begin
                resp_n  = reg_rdata;
                state_n = SEND;
            end
            SEND: begin
                wr_uart = !tx_full;
                if (!tx_full) state_n = CMD_REQ;
            end
            default: state_n = CMD_REQ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CMD_REQ;
            cmd       <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            resp      <= '0;
            tmo_cnt   <= '0;
        end else begin
            state   <= state_n;
            resp    <= resp_n;
            tmo_cnt <= tmo_n;
            if (state == CMD_CAP)  cmd       <= r_data;
            if (state == ADDR_CAP) reg_addr  <= r_data;
            if (state == DATA_CAP) reg_wdata <= r_data;
        end
    end

endmodule
